ddr3_req_arbiter: RTL and testbench

//  Shares the DDR3 controller user (app_*) port between the gray-pixel write path
//  and the LED-zone read path. Queues write requests ({addr,48b data}) and read

---
 rtl/ddr_arb_defs_pkg.sv | 28 ++
 rtl/ddr_req_fifo.sv | 55 +++++
 rtl/ddr3_req_arbiter.sv | 255 +++++++++++++++++++++++++
 tb/tb_ddr3_req_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_arb_defs_pkg.sv
// Shared definitions for the DDR3 request arbiter: controller command
// encodings, arbiter FSM state encodings, the write-data byte mask and a
// saturating-increment helper used by the optional statistics counters.
package ddr_arb_defs_pkg;

  localparam logic [2:0] CMD_WR   = 3'b000;
  localparam logic [2:0] CMD_RD   = 3'b001;

  // Upper two bytes of the 64-bit beat carry no pixel data.
  localparam logic [7:0] WDF_MASK = 8'hC0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_ISSUE = 2'd1,
    RD_ISSUE = 2'd2
  } arb_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ddr_req_fifo.sv
// Synchronous request FIFO with full/empty/level status.
// A push on a full FIFO is taken only when a pop happens in the same cycle,
// in which case the level is unchanged.
module ddr_req_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wptr_r;
  logic [AW:0]      rptr_r;
  logic             pop_ok_s;
  logic             push_ok_s;

  assign level     = wptr_r - rptr_r;
  assign empty     = (wptr_r == rptr_r);
  assign full      = (level == DEPTH[AW:0]);
  assign head      = mem_r[rptr_r[AW-1:0]];
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);

  // Read/write pointers; one extra bit distinguishes full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (push_ok_s) begin
        wptr_r <= wptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (pop_ok_s) begin
        rptr_r <= rptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Entry storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wptr_r[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/ddr3_req_arbiter.sv
// ddr3_req_arbiter: shares the DDR3 controller app_* port between the gray
// pixel write path and the LED-zone read path. Writes ({addr,48b data}) and
// reads (addr) are queued in separate FIFOs; an IDLE/WR_ISSUE/RD_ISSUE FSM
// grants one at a time (urgent writes first, else round-robin) and bounds
// reads in flight. Every app_* output comes straight from a flop; a granted
// request therefore spends one cycle in its ISSUE state before app_en rises.
// Optional feature: define ARB_STATS_EN to get saturating grant/stall
// counters on stats_o; otherwise stats_o is constant zero.
module ddr3_req_arbiter
  import ddr_arb_defs_pkg::*;
#(
  parameter int ADDR_W      = 28,
  parameter int ADDR_LSB    = 3,
  parameter int WFIFO_DEPTH = 16,
  parameter int RFIFO_DEPTH = 16,
  parameter int WR_URGENT   = 12,
  parameter int MAX_RD_OUT  = 4
) (
  input  logic              clk_x1,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [15:0]       wr_addr,
  input  logic [47:0]       wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [15:0]       rd_addr,
  input  logic              app_rdy,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  input  logic              app_wdf_rdy,
  output logic              app_wdf_wren,
  output logic [63:0]       app_wdf_data,
  output logic              app_wdf_end,
  output logic [7:0]        app_wdf_mask,
  input  logic              app_rd_data_end,
  output logic [2:0]        rd_outstanding,
  output logic [47:0]       stats_o
);

  localparam int WAW = $clog2(WFIFO_DEPTH);
  localparam int RAW = $clog2(RFIFO_DEPTH);

  // FIFO interfaces
  logic [63:0]  wfifo_head_s;
  logic         wfifo_full_s;
  logic         wfifo_empty_s;
  logic [WAW:0] wfifo_level_s;
  logic [15:0]  rfifo_head_s;
  logic         rfifo_full_s;
  logic         rfifo_empty_s;
  logic [RAW:0] rfifo_level_s;
  logic         unused_rlevel_s;

  // FSM and handshake state
  arb_state_e   state_r;
  arb_state_e   state_nx_s;
  logic         cmd_done_r;
  logic         cmd_done_nx_s;
  logic         dat_done_r;
  logic         dat_done_nx_s;
  logic         prio_rd_r;
  logic         prio_rd_nx_s;
  logic         app_en_nx_s;
  logic         wren_nx_s;
  logic         wr_pop_s;
  logic         rd_pop_s;
  logic         cmd_acc_s;
  logic         dat_acc_s;
  logic         wr_elig_s;
  logic         rd_elig_s;
  logic         wr_urgent_s;
  logic         rd_dec_s;

  // Registered outputs
  logic              app_en_r;
  logic [2:0]        app_cmd_r;
  logic [ADDR_W-1:0] app_addr_r;
  logic              app_wdf_wren_r;
  logic [63:0]       app_wdf_data_r;
  logic [7:0]        app_wdf_mask_r;
  logic [2:0]        rd_out_r;

  assign wr_ready        = ~wfifo_full_s;
  assign rd_ready        = ~rfifo_full_s;
  assign unused_rlevel_s = ^rfifo_level_s;

  ddr_req_fifo #(.WIDTH(64), .DEPTH(WFIFO_DEPTH)) u_wfifo (
    .clk       (clk_x1),
    .rst_n     (rst_n),
    .push      (wr_valid & wr_ready),
    .push_data ({wr_addr, wr_data}),
    .pop       (wr_pop_s),
    .head      (wfifo_head_s),
    .full      (wfifo_full_s),
    .empty     (wfifo_empty_s),
    .level     (wfifo_level_s)
  );

  ddr_req_fifo #(.WIDTH(16), .DEPTH(RFIFO_DEPTH)) u_rfifo (
    .clk       (clk_x1),
    .rst_n     (rst_n),
    .push      (rd_valid & rd_ready),
    .push_data (rd_addr),
    .pop       (rd_pop_s),
    .head      (rfifo_head_s),
    .full      (rfifo_full_s),
    .empty     (rfifo_empty_s),
    .level     (rfifo_level_s)
  );

  assign cmd_acc_s   = app_en_r & app_rdy;
  assign dat_acc_s   = app_wdf_wren_r & app_wdf_rdy;
  assign wr_elig_s   = ~wfifo_empty_s;
  assign rd_elig_s   = ~rfifo_empty_s && (rd_out_r < MAX_RD_OUT[2:0]);
  assign wr_urgent_s = (wfifo_level_s >= WR_URGENT[WAW:0]);
  assign rd_dec_s    = app_rd_data_end && (rd_out_r != 3'd0);

  // Grant selection, issue handshakes and next values of the command flops
  always_comb begin
    state_nx_s    = state_r;
    cmd_done_nx_s = cmd_done_r;
    dat_done_nx_s = dat_done_r;
    prio_rd_nx_s  = prio_rd_r;
    app_en_nx_s   = 1'b0;
    wren_nx_s     = 1'b0;
    wr_pop_s      = 1'b0;
    rd_pop_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (wr_urgent_s || (wr_elig_s && !(rd_elig_s && prio_rd_r))) begin
          state_nx_s   = WR_ISSUE;
          prio_rd_nx_s = 1'b1;
        end else if (rd_elig_s) begin
          state_nx_s   = RD_ISSUE;
          prio_rd_nx_s = 1'b0;
        end else begin
          state_nx_s   = IDLE;
        end
      end
      WR_ISSUE: begin
        // Command and data channels complete independently, in any order.
        cmd_done_nx_s = cmd_done_r | cmd_acc_s;
        dat_done_nx_s = dat_done_r | dat_acc_s;
        if (cmd_done_nx_s && dat_done_nx_s) begin
          wr_pop_s      = 1'b1;
          state_nx_s    = IDLE;
          cmd_done_nx_s = 1'b0;
          dat_done_nx_s = 1'b0;
        end else begin
          app_en_nx_s   = ~cmd_done_nx_s;
          wren_nx_s     = ~dat_done_nx_s;
        end
      end
      RD_ISSUE: begin
        if (cmd_acc_s) begin
          rd_pop_s    = 1'b1;
          state_nx_s  = IDLE;
        end else begin
          app_en_nx_s = 1'b1;
        end
      end
      default: begin
        state_nx_s    = IDLE;
        cmd_done_nx_s = 1'b0;
        dat_done_nx_s = 1'b0;
      end
    endcase
  end

  // FSM state, round-robin pointer, handshake flags and app_* output flops
  always_ff @(posedge clk_x1 or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      cmd_done_r     <= 1'b0;
      dat_done_r     <= 1'b0;
      prio_rd_r      <= 1'b1;
      app_en_r       <= 1'b0;
      app_cmd_r      <= 3'b000;
      app_addr_r     <= '0;
      app_wdf_wren_r <= 1'b0;
      app_wdf_data_r <= 64'h0;
      app_wdf_mask_r <= 8'h00;
    end else begin
      state_r        <= state_nx_s;
      cmd_done_r     <= cmd_done_nx_s;
      dat_done_r     <= dat_done_nx_s;
      prio_rd_r      <= prio_rd_nx_s;
      app_en_r       <= app_en_nx_s;
      app_wdf_wren_r <= wren_nx_s;
      app_wdf_mask_r <= wren_nx_s ? WDF_MASK : 8'h00;
      if (state_r == WR_ISSUE) begin
        app_cmd_r      <= CMD_WR;
        app_addr_r     <= ADDR_W'({wfifo_head_s[63:48], {ADDR_LSB{1'b0}}});
        app_wdf_data_r <= {16'h0000, wfifo_head_s[47:0]};
      end else if (state_r == RD_ISSUE) begin
        app_cmd_r      <= CMD_RD;
        app_addr_r     <= ADDR_W'({rfifo_head_s, {ADDR_LSB{1'b0}}});
      end
    end
  end

  // Reads in flight: +1 on read command accept, -1 per returned read
  always_ff @(posedge clk_x1 or negedge rst_n) begin
    if (!rst_n) begin
      rd_out_r <= 3'd0;
    end else begin
      case ({rd_pop_s, rd_dec_s})
        2'b10:   rd_out_r <= rd_out_r + 3'd1;
        2'b01:   rd_out_r <= rd_out_r - 3'd1;
        default: rd_out_r <= rd_out_r;
      endcase
    end
  end

  assign app_en         = app_en_r;
  assign app_cmd        = app_cmd_r;
  assign app_addr       = app_addr_r;
  assign app_wdf_wren   = app_wdf_wren_r;
  assign app_wdf_end    = app_wdf_wren_r;
  assign app_wdf_data   = app_wdf_data_r;
  assign app_wdf_mask   = app_wdf_mask_r;
  assign rd_outstanding = rd_out_r;

`ifdef ARB_STATS_EN
  logic [15:0] wr_grant_cnt_r;
  logic [15:0] rd_grant_cnt_r;
  logic [15:0] stall_cnt_r;

  // Saturating counts of completed writes, accepted reads and stalled command cycles
  always_ff @(posedge clk_x1 or negedge rst_n) begin
    if (!rst_n) begin
      wr_grant_cnt_r <= 16'h0000;
      rd_grant_cnt_r <= 16'h0000;
      stall_cnt_r    <= 16'h0000;
    end else begin
      if (wr_pop_s) begin
        wr_grant_cnt_r <= sat_inc16(wr_grant_cnt_r);
      end
      if (rd_pop_s) begin
        rd_grant_cnt_r <= sat_inc16(rd_grant_cnt_r);
      end
      if (app_en_r && !app_rdy) begin
        stall_cnt_r <= sat_inc16(stall_cnt_r);
      end
    end
  end

  assign stats_o = {stall_cnt_r, rd_grant_cnt_r, wr_grant_cnt_r};
`else
  assign stats_o = 48'h0;
`endif

endmodule

// File: tb/tb_ddr3_req_arbiter.sv
// Directed, scoreboard-based bench for ddr3_req_arbiter. Expected commands
// and write beats are queued as stimulus is driven; a negedge monitor pops
// and compares them whenever the controller side accepts a command or beat.
module tb_ddr3_req_arbiter;

  logic        clk_x1 = 1'b0;
  logic        rst_n  = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_addr = 16'h0;
  logic [47:0] wr_data = 48'h0;
  logic        rd_valid = 1'b0;
  logic        rd_ready;
  logic [15:0] rd_addr = 16'h0;
  logic        app_rdy = 1'b0;
  logic        app_en;
  logic [2:0]  app_cmd;
  logic [27:0] app_addr;
  logic        app_wdf_rdy = 1'b0;
  logic        app_wdf_wren;
  logic [63:0] app_wdf_data;
  logic        app_wdf_end;
  logic [7:0]  app_wdf_mask;
  logic        app_rd_data_end = 1'b0;
  logic [2:0]  rd_outstanding;
  logic [47:0] stats_o;

  always #5 clk_x1 = ~clk_x1;

  ddr3_req_arbiter dut (
    .clk_x1          (clk_x1),
    .rst_n           (rst_n),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .rd_valid        (rd_valid),
    .rd_ready        (rd_ready),
    .rd_addr         (rd_addr),
    .app_rdy         (app_rdy),
    .app_en          (app_en),
    .app_cmd         (app_cmd),
    .app_addr        (app_addr),
    .app_wdf_rdy     (app_wdf_rdy),
    .app_wdf_wren    (app_wdf_wren),
    .app_wdf_data    (app_wdf_data),
    .app_wdf_end     (app_wdf_end),
    .app_wdf_mask    (app_wdf_mask),
    .app_rd_data_end (app_rd_data_end),
    .rd_outstanding  (rd_outstanding),
    .stats_o         (stats_o)
  );

  typedef struct {
    logic [2:0]  cmd;
    logic [27:0] addr;
  } cmd_t;

  cmd_t        exp_cmd_q [$];
  logic [63:0] exp_dat_q [$];
  cmd_t        mon_e;
  logic [63:0] mon_d;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_cmd    = 0;
  int          n_beat   = 0;

  function automatic logic [27:0] map_addr(input logic [15:0] a);
    return {9'h000, a, 3'b000};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_x1);
    #1;
  endtask

  task automatic sb_wr(input logic [15:0] a, input logic [47:0] d);
    cmd_t e;
    e.cmd  = 3'b000;
    e.addr = map_addr(a);
    exp_cmd_q.push_back(e);
    exp_dat_q.push_back({16'h0000, d});
  endtask

  task automatic sb_rd(input logic [15:0] a);
    cmd_t e;
    e.cmd  = 3'b001;
    e.addr = map_addr(a);
    exp_cmd_q.push_back(e);
  endtask

  task automatic drive(input logic wv, input logic [15:0] wa, input logic [47:0] wd,
                       input logic rv, input logic [15:0] ra);
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd_valid = rv; rd_addr = ra;
    tick();
    wr_valid = 1'b0;
    rd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n;
    n = 0;
    while ((exp_cmd_q.size() != 0 || exp_dat_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(exp_cmd_q.size() + exp_dat_q.size()), 64'd0);
  endtask

  task automatic check_idle(input string t);
    check({t, "_app_en"},   64'(app_en),         64'd0);
    check({t, "_app_cmd"},  64'(app_cmd),        64'd0);
    check({t, "_app_addr"}, 64'(app_addr),       64'd0);
    check({t, "_wren"},     64'(app_wdf_wren),   64'd0);
    check({t, "_wdf_data"}, app_wdf_data,        64'd0);
    check({t, "_wdf_end"},  64'(app_wdf_end),    64'd0);
    check({t, "_wdf_mask"}, 64'(app_wdf_mask),   64'd0);
    check({t, "_rd_out"},   64'(rd_outstanding), 64'd0);
    check({t, "_wr_ready"}, 64'(wr_ready),       64'd1);
    check({t, "_rd_ready"}, 64'(rd_ready),       64'd1);
    check({t, "_stats"},    64'(stats_o),        64'd0);
  endtask

  task automatic do_reset(input string t);
    rst_n = 1'b0;
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    app_rd_data_end = 1'b0;
    exp_cmd_q.delete();
    exp_dat_q.delete();
    tick();
    tick();
    check_idle(t);
    rst_n = 1'b1;
    tick();
  endtask

  // Scoreboard monitor: compare accepted commands and write beats at the falling edge
  always @(negedge clk_x1) begin
    if (rst_n && app_en && app_rdy) begin
      n_cmd++;
      check("cmd_expected", 64'(exp_cmd_q.size() != 0), 64'd1);
      if (exp_cmd_q.size() != 0) begin
        mon_e = exp_cmd_q.pop_front();
        check("app_cmd", 64'(app_cmd), 64'(mon_e.cmd));
        check("app_addr", 64'(app_addr), 64'(mon_e.addr));
      end
    end
    if (rst_n && app_wdf_wren && app_wdf_rdy) begin
      n_beat++;
      check("beat_expected", 64'(exp_dat_q.size() != 0), 64'd1);
      if (exp_dat_q.size() != 0) begin
        mon_d = exp_dat_q.pop_front();
        check("app_wdf_data", app_wdf_data, mon_d);
      end
      check("app_wdf_mask", 64'(app_wdf_mask), 64'hC0);
      check("app_wdf_end", 64'(app_wdf_end), 64'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int beat0;
    int cmd0;
    int en_cnt;
    int wren_cnt;
    int acc;

    // ---- Test 1: single write, latency and beat format ----
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    do_reset("rst1");
    app_rd_data_end = 1'b1;
    tick();
    app_rd_data_end = 1'b0;
    check("rdout_dec_at_zero", 64'(rd_outstanding), 64'd0);
    sb_wr(16'h0012, 48'hA1B2C3D4E5F6);
    beat0 = n_beat;
    drive(1'b1, 16'h0012, 48'hA1B2C3D4E5F6, 1'b0, 16'h0);
    tick();
    check("t1_en_n1", 64'(app_en), 64'd0);
    tick();
    check("t1_en_n2",   64'(app_en),       64'd1);
    check("t1_cmd",     64'(app_cmd),      64'd0);
    check("t1_addr",    64'(app_addr),     64'h90);
    check("t1_wren",    64'(app_wdf_wren), 64'd1);
    check("t1_data",    app_wdf_data,      64'h0000A1B2C3D4E5F6);
    check("t1_mask",    64'(app_wdf_mask), 64'hC0);
    check("t1_end",     64'(app_wdf_end),  64'd1);
    tick();
    check("t1_en_done",   64'(app_en),          64'd0);
    check("t1_wren_done", 64'(app_wdf_wren),    64'd0);
    check("t1_one_beat",  64'(n_beat - beat0),  64'd1);

    // ---- Test 2: write data accepted late ----
    do_reset("rst2");
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b0;
    sb_wr(16'h0345, 48'h123456789ABC);
    en_cnt = 0;
    wren_cnt = 0;
    drive(1'b1, 16'h0345, 48'h123456789ABC, 1'b0, 16'h0);
    repeat (30) begin
      tick();
      if (app_en) en_cnt++;
      if (app_wdf_wren) wren_cnt++;
      if (wren_cnt == 6) app_wdf_rdy = 1'b1;
    end
    check("t2_en_cycles",   64'(en_cnt),   64'd1);
    check("t2_wren_cycles", 64'(wren_cnt), 64'd6);
    wait_drain(5, "t2_drain");

    // ---- Test 3a: round-robin alternation ----
    do_reset("rst3");
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    sb_wr(16'h0100, 48'h000000001000);
    sb_rd(16'h0200);
    sb_wr(16'h0101, 48'h000000001001);
    sb_rd(16'h0201);
    sb_wr(16'h0102, 48'h000000001002);
    sb_rd(16'h0202);
    drive(1'b1, 16'h0100, 48'h000000001000, 1'b0, 16'h0);
    drive(1'b1, 16'h0101, 48'h000000001001, 1'b1, 16'h0200);
    drive(1'b1, 16'h0102, 48'h000000001002, 1'b1, 16'h0201);
    drive(1'b0, 16'h0,    48'h0,            1'b1, 16'h0202);
    wait_drain(80, "t3_drain");

    // ---- Test 3b: urgent write level ----
    do_reset("rst3b");
    app_rdy = 1'b0;
    app_wdf_rdy = 1'b1;
    sb_rd(16'h0300);
    sb_wr(16'h0400, 48'h000000002000);
    sb_wr(16'h0401, 48'h000000002001);
    sb_rd(16'h0301);
    for (int i = 2; i < 13; i++) sb_wr(16'(16'h0400 + i), 48'(48'h2000 + i));
    drive(1'b0, 16'h0, 48'h0, 1'b1, 16'h0300);
    drive(1'b0, 16'h0, 48'h0, 1'b1, 16'h0301);
    for (int i = 0; i < 13; i++) drive(1'b1, 16'(16'h0400 + i), 48'(48'h2000 + i), 1'b0, 16'h0);
    check("t3b_stuck_en",  64'(app_en),  64'd1);
    check("t3b_stuck_cmd", 64'(app_cmd), 64'd1);
    app_rdy = 1'b1;
    wait_drain(200, "t3b_drain");
    tick();
    check("t3b_rd_out", 64'(rd_outstanding), 64'd2);

    // ---- Test 4: outstanding read limit ----
    do_reset("rst4");
    app_rdy = 1'b1;
    for (int i = 0; i < 4; i++) sb_rd(16'(16'h0500 + i));
    cmd0 = n_cmd;
    for (int i = 0; i < 8; i++) drive(1'b0, 16'h0, 48'h0, 1'b1, 16'(16'h0500 + i));
    repeat (40) tick();
    check("t4_cmds_4",   64'(n_cmd - cmd0),   64'd4);
    check("t4_rd_out_4", 64'(rd_outstanding), 64'd4);
    check("t4_q_empty",  64'(exp_cmd_q.size()), 64'd0);
    sb_rd(16'h0504);
    app_rd_data_end = 1'b1;
    tick();
    app_rd_data_end = 1'b0;
    wait_drain(30, "t4_drain");
    repeat (10) tick();
    check("t4_cmds_5",   64'(n_cmd - cmd0),   64'd5);
    check("t4_rd_out_5", 64'(rd_outstanding), 64'd4);

    // ---- Test 5: full write FIFO, then reset mid WR_ISSUE ----
    do_reset("rst5");
    app_rdy = 1'b0;
    app_wdf_rdy = 1'b0;
    acc = 0;
    for (int i = 0; i < 17; i++) begin
      wr_valid = 1'b1;
      wr_addr  = 16'(16'h0600 + i);
      wr_data  = 48'(48'h3000 + i);
      if (wr_ready) acc++;
      tick();
    end
    wr_valid = 1'b0;
    check("t5_accepted", 64'(acc),          64'd16);
    check("t5_wr_ready", 64'(wr_ready),     64'd0);
    check("t5_en_held",  64'(app_en),       64'd1);
    check("t5_wren",     64'(app_wdf_wren), 64'd1);
    rst_n = 1'b0;
    #1;
    check_idle("t5_rst");
    tick();
    rst_n = 1'b1;
    tick();
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    cmd0 = n_cmd;
    sb_wr(16'h0ABC, 48'hFEDCBA987654);
    drive(1'b1, 16'h0ABC, 48'hFEDCBA987654, 1'b0, 16'h0);
    wait_drain(30, "t5_drain");
    repeat (10) tick();
    check("t5_one_cmd", 64'(n_cmd - cmd0), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
